// File: rtl/adc_sample_averager.sv
// Averages windows of 2^LOG2_AVG ADC samples and queues each truncated mean
// in a small output FIFO with a valid/ready read side and a sticky drop flag.
module adc_sample_averager #(
    parameter int DATA_W     = 16,
    parameter int LOG2_AVG   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          SCLK,
    input  logic                          RST,
    input  logic [DATA_W-1:0]             IN_DATA,
    input  logic                          IN_VALID,
    output logic [DATA_W-1:0]             OUT_DATA,
    output logic                          OUT_VALID,
    input  logic                          OUT_READY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic [LOG2_AVG-1:0]           SAMPLE_CNT,
    output logic                          OVERFLOW
);

    localparam int ACC_W = DATA_W + LOG2_AVG;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    sum;
    logic [LOG2_AVG-1:0] sample_cnt;
    logic                window_done;
    logic [DATA_W-1:0]   avg;

    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [LVL_W-1:0]    level;
    logic                overflow;
    logic                empty;
    logic                full;
    logic                pop;
    logic                push_ok;
    logic                drop;

    // Accumulator is wide enough that a full window of max-scale samples never wraps.
    always_comb begin
        sum         = acc + ACC_W'(IN_DATA);
        window_done = IN_VALID && (sample_cnt == '1);
        avg         = sum[ACC_W-1:LOG2_AVG];
    end

    always_ff @(posedge SCLK) begin
        if (RST) begin
            acc        <= '0;
            sample_cnt <= '0;
        end else if (IN_VALID) begin
            if (window_done) begin
                acc        <= '0;
                sample_cnt <= '0;
            end else begin
                acc        <= sum;
                sample_cnt <= sample_cnt + 1'b1;
            end
        end
    end

    // Full/empty come from the occupancy count; pointers alone are ambiguous.
    always_comb begin
        empty   = (level == '0);
        full    = (level == LVL_W'(FIFO_DEPTH));
        pop     = !empty && OUT_READY;
        push_ok = window_done && (!full || pop);
        drop    = window_done && full && !pop;
    end

    always_ff @(posedge SCLK) begin
        if (!RST && push_ok) begin
            mem[wr_ptr] <= avg;
        end
    end

    always_ff @(posedge SCLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Head is forced to zero when empty so stale entries never show after reset.
    always_comb begin
        OUT_VALID  = !empty;
        OUT_DATA   = empty ? '0 : mem[rd_ptr];
        FIFO_LEVEL = level;
        SAMPLE_CNT = sample_cnt;
        OVERFLOW   = overflow;
    end

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed-vector bench: stimulus pushes expected averages into a queue and a
// negedge monitor compares them whenever the DUT hands out an entry.
module tb_adc_sample_averager;

    logic        SCLK = 1'b0;
    logic        RST;
    logic [15:0] IN_DATA;
    logic        IN_VALID;
    logic [15:0] OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [2:0]  FIFO_LEVEL;
    logic [2:0]  SAMPLE_CNT;
    logic        OVERFLOW;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [15:0] sb [$];

    adc_sample_averager #(
        .DATA_W     (16),
        .LOG2_AVG   (3),
        .FIFO_DEPTH (4)
    ) dut (
        .SCLK       (SCLK),
        .RST        (RST),
        .IN_DATA    (IN_DATA),
        .IN_VALID   (IN_VALID),
        .OUT_DATA   (OUT_DATA),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .FIFO_LEVEL (FIFO_LEVEL),
        .SAMPLE_CNT (SAMPLE_CNT),
        .OVERFLOW   (OVERFLOW)
    );

    always #5 SCLK = ~SCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen at negedge becomes a pop at the next posedge.
    always @(negedge SCLK) begin
        if (!RST && OUT_VALID && OUT_READY) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pop: got 0x%0h, expected no entry", OUT_DATA);
            end else begin
                logic [15:0] exp;
                exp = sb.pop_front();
                if (OUT_DATA !== exp) begin
                    n_fail++;
                    $display("FAIL pop_data: got 0x%0h, expected 0x%0h", OUT_DATA, exp);
                end
            end
        end
    end

    task automatic sample(input logic [15:0] d);
        IN_DATA  = d;
        IN_VALID = 1'b1;
        @(posedge SCLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge SCLK);
        #1;
        RST = 1'b0;
        sb.delete();
    endtask

    task automatic drain(input string name);
        bit done = 0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge SCLK);
            #1;
            if (sb.size() == 0 && FIFO_LEVEL == 3'd0) begin
                done = 1;
                break;
            end
        end
        OUT_READY = 1'b0;
        check({name, "_drain_done"}, 32'(done), 32'd1);
        check({name, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        RST       = 1'b1;
        IN_DATA   = '0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        repeat (2) @(posedge SCLK);
        #1;
        RST = 1'b0;

        check("rst_valid", OUT_VALID, 0);
        check("rst_data", OUT_DATA, 0);
        check("rst_level", FIFO_LEVEL, 0);
        check("rst_cnt", SAMPLE_CNT, 0);
        check("rst_ovf", OVERFLOW, 0);

        // Constant 0x1000 window, latency of one cycle
        for (int i = 0; i < 7; i++) sample(16'h1000);
        check("w1_cnt7", SAMPLE_CNT, 7);
        check("w1_valid_early", OUT_VALID, 0);
        sb.push_back(16'h1000);
        sample(16'h1000);
        check("w1_valid", OUT_VALID, 1);
        check("w1_data", OUT_DATA, 32'h1000);
        check("w1_level", FIFO_LEVEL, 1);
        check("w1_cnt0", SAMPLE_CNT, 0);
        drain("w1");

        // Ramp 1..8: 36>>3 truncates to 4
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) sb.push_back(16'h0004);
            sample(16'(i));
        end
        check("ramp_data", OUT_DATA, 4);
        check("ramp_cnt0", SAMPLE_CNT, 0);
        drain("ramp");

        // Full-scale samples must not wrap
        for (int i = 0; i < 8; i++) begin
            if (i == 7) sb.push_back(16'hFFFF);
            sample(16'hFFFF);
        end
        check("max_data", OUT_DATA, 32'hFFFF);
        check("max_ovf", OVERFLOW, 0);
        drain("max");

        // Back-to-back windows with consumer ready; no bypass on empty push
        OUT_READY = 1'b1;
        sb.push_back(16'd35);
        sb.push_back(16'd103);
        for (int i = 0; i < 8; i++) sample(16'(10 * i));
        check("b2b_level1", FIFO_LEVEL, 1);
        check("b2b_data1", OUT_DATA, 35);
        for (int i = 0; i < 8; i++) sample(16'(100 + i));
        check("b2b_level2", FIFO_LEVEL, 1);
        check("b2b_data2", OUT_DATA, 103);
        drain("b2b");

        // Five windows with consumer stalled: fifth is dropped
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) sb.push_back(16'(k));
            for (int i = 0; i < 8; i++) sample(16'(k));
            if (k == 4) begin
                check("fill_level4", FIFO_LEVEL, 4);
                check("fill_ovf_before", OVERFLOW, 0);
            end
        end
        check("ovf_level", FIFO_LEVEL, 4);
        check("ovf_flag", OVERFLOW, 1);
        check("ovf_head_held", OUT_DATA, 1);
        drain("ovf");
        check("ovf_sticky", OVERFLOW, 1);
        do_reset();
        check("ovf_cleared", OVERFLOW, 0);

        // Full FIFO with pop in the completing cycle: push and pop both land
        for (int k = 1; k <= 4; k++) begin
            sb.push_back(16'(k * 16));
            for (int i = 0; i < 8; i++) sample(16'(k * 16));
        end
        check("full_level", FIFO_LEVEL, 4);
        check("full_head", OUT_DATA, 32'h10);
        sb.push_back(16'h50);
        for (int i = 0; i < 7; i++) sample(16'h50);
        OUT_READY = 1'b1;
        sample(16'h50);
        OUT_READY = 1'b0;
        check("pp_level", FIFO_LEVEL, 4);
        check("pp_ovf", OVERFLOW, 0);
        check("pp_head", OUT_DATA, 32'h20);
        drain("pp");

        // Reset discards buffered results and a partial window
        for (int i = 0; i < 8; i++) sample(16'h0700);
        for (int i = 0; i < 5; i++) sample(16'h0200);
        check("pre_rst_cnt", SAMPLE_CNT, 5);
        do_reset();
        check("mid_rst_cnt", SAMPLE_CNT, 0);
        check("mid_rst_valid", OUT_VALID, 0);
        check("mid_rst_level", FIFO_LEVEL, 0);
        for (int i = 0; i < 7; i++) sample(16'h0300);
        check("post_rst_valid_early", OUT_VALID, 0);
        sb.push_back(16'h0300);
        sample(16'h0300);
        check("post_rst_valid", OUT_VALID, 1);
        check("post_rst_data", OUT_DATA, 32'h0300);
        drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_sample_averager.md
ADC_SAMPLE_AVERAGER -- requirements
Module: adc_sample_averager

Interface
REQ-001 Parameter DATA_W, default 16: ADC sample word width in bits.
REQ-002 Parameter LOG2_AVG, default 3: log2 of samples per average (8 by default); legal range 1..6.
REQ-003 Parameter FIFO_DEPTH, default 4: output FIFO entries; power of two, at least 2.
REQ-004 SCLK  input  1  single clock for the block; all state updates on rising edge.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 IN_DATA  input  DATA_W  unsigned sample word from the upstream ADC SPI interface.
REQ-007 IN_VALID  input  1  one-cycle strobe; IN_DATA is valid in that cycle; no backpressure upstream.
REQ-008 OUT_DATA  output  DATA_W  averaged sample at the FIFO head.
REQ-009 OUT_VALID  output  1  high while the FIFO is non-empty.
REQ-010 OUT_READY  input  1  consumer accept; a pop occurs when OUT_VALID and OUT_READY are both high.
REQ-011 FIFO_LEVEL  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH.
REQ-012 SAMPLE_CNT  output  LOG2_AVG  samples accumulated in the current window, 0..2^LOG2_AVG-1.
REQ-013 OVERFLOW  output  1  sticky flag; set when a completed average is dropped.

Function
REQ-014 The accumulator shall be DATA_W+LOG2_AVG bits wide, so no intermediate sum can wrap.
REQ-015 Each IN_VALID cycle shall add IN_DATA (zero-extended) to the accumulator and increment SAMPLE_CNT.
REQ-016 When IN_VALID arrives with SAMPLE_CNT = 2^LOG2_AVG-1, the block shall form (accumulator + IN_DATA) >> LOG2_AVG.
- Truncating division; no rounding.
- Same edge: accumulator and SAMPLE_CNT cleared to 0.
- Same edge: the result is pushed into the FIFO.
REQ-017 Latency: OUT_VALID shall rise, with the result on OUT_DATA, in the cycle after the edge that captured the final sample of the window, provided the FIFO was empty.
REQ-018 Back-to-back windows shall be supported with no dead cycle.
- IN_VALID may be high every cycle.
- The first sample of the next window may arrive in the cycle after the completing sample.
REQ-019 The FIFO shall be first-in first-out.
- OUT_DATA is the oldest entry.
- While OUT_VALID is high and OUT_READY is low, OUT_DATA shall not change.
REQ-020 A pop shall advance to the next entry on the same edge; OUT_VALID shall fall once the last entry has been popped.
REQ-021 A push and a pop in the same cycle shall both take effect.
- FIFO_LEVEL unchanged.
- Applies also when the FIFO is full.
REQ-022 A push into a full FIFO with no simultaneous pop shall discard the new result.
- FIFO contents unchanged.
- OVERFLOW set on that edge and held until reset.
REQ-023 A push into an empty FIFO with OUT_READY high shall not bypass: the entry appears first and is popped at the earliest on the following edge.
REQ-024 Read and write pointers shall wrap modulo FIFO_DEPTH.
- Full/empty detection uses FIFO_LEVEL, never pointer equality alone.
REQ-025 IN_VALID shall have no effect on OUT_DATA, OUT_VALID or FIFO_LEVEL except via REQ-016.

Reset
REQ-026 With RST high at a rising edge, the block shall clear all state at that edge.
- Accumulator, SAMPLE_CNT, FIFO pointers, FIFO_LEVEL and OVERFLOW to 0.
- OUT_VALID to 0, OUT_DATA to 0.
REQ-027 RST shall take priority over IN_VALID and OUT_READY in the same cycle.
- A partially accumulated window is discarded.
- Buffered results are lost.
REQ-028 The first window after reset shall require a full 2^LOG2_AVG fresh samples.

Verification
REQ-029 Eight IN_VALID strobes of 0x1000 (defaults) -> OUT_DATA=0x1000, OUT_VALID=1 one cycle after the 8th, FIFO_LEVEL=1.
REQ-030 Samples 1,2,...,8 -> OUT_DATA=0x0004 (36>>3, truncated); SAMPLE_CNT returns to 0.
REQ-031 Eight samples of 0xFFFF on consecutive cycles -> OUT_DATA=0xFFFF, OVERFLOW=0.
REQ-032 OUT_READY held low, 40 samples (5 windows) -> FIFO_LEVEL=4, OVERFLOW=1; pops then return averages 1-4 in order, the 5th having been dropped.
REQ-033 FIFO full, OUT_READY high in the completing cycle of a window -> FIFO_LEVEL stays 4, OVERFLOW stays 0, new result at the tail.
REQ-034 RST pulsed after 5 samples of a window -> SAMPLE_CNT=0; the next OUT_VALID occurs only after 8 further samples, with their average.
